// File: rtl/mem_stage_access_ctrl.sv
// MEM-stage data-cache access controller: drives dcache requests from the EX/MEM latch,
// stalls until dhit, captures load data and suppresses re-issue while the pipeline is frozen.
module mem_stage_access_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ren_i,
    input  logic             wen_i,
    input  logic [31:0]      addr_i,
    input  logic [31:0]      store_i,
    input  logic             halt_i,
    input  logic             adv_i,
    input  logic             dhit,
    input  logic [31:0]      dmemload,
    output logic             dmemREN,
    output logic             dmemWEN,
    output logic [31:0]      dmemaddr,
    output logic [31:0]      dmemstore,
    output logic [31:0]      load_o,
    output logic             mem_stall,
    output logic             misalign_o,
    output logic             err_o,
    output logic             halt_o,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        HOLD,
        HALT
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [31:0]       r_load;
    logic              r_misalign;
    logic              r_err;
    logic              r_halt;
    logic [CNT_W-1:0]  r_stallCnt;
    logic [31:0]       r_waitCnt;

    logic              w_op;
    logic              w_aligned;
    logic              w_reqState;
    logic              w_req;
    logic              w_capture;
    logic              w_misalign;
    logic              w_timeout;

    assign w_op       = ren_i | wen_i;
    assign w_aligned  = (addr_i[1:0] == 2'b00);
    assign w_reqState = (r_state == IDLE) || (r_state == ACCESS);
    assign w_req      = w_op & w_aligned & ~halt_i & w_reqState;

    // A simultaneous read and write is treated as a store.
    assign dmemREN    = w_req & ren_i & ~wen_i;
    assign dmemWEN    = w_req & wen_i;
    assign dmemaddr   = w_req ? addr_i  : 32'd0;
    assign dmemstore  = w_req ? store_i : 32'd0;
    assign mem_stall  = w_req & ~dhit;

    assign w_capture  = w_req & dhit & ren_i & ~wen_i;
    assign w_misalign = (r_state == IDLE) & ~halt_i & w_op & ~w_aligned;
    assign w_timeout  = (TIMEOUT != 0) && (r_state == ACCESS) && !dhit &&
                        (r_waitCnt == 32'(TIMEOUT - 1));

    assign load_o     = r_load;
    assign misalign_o = r_misalign;
    assign err_o      = r_err;
    assign halt_o     = r_halt;
    assign stall_cnt  = r_stallCnt;

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (halt_i)
                    w_nextState = HALT;
                else if (w_req && dhit)
                    w_nextState = adv_i ? IDLE : HOLD;
                else if (w_req)
                    w_nextState = ACCESS;
            end
            ACCESS: begin
                // If the latched operation vanishes, fall back and re-evaluate from IDLE.
                if (!w_req)
                    w_nextState = IDLE;
                else if (dhit)
                    w_nextState = adv_i ? IDLE : HOLD;
            end
            HOLD: begin
                if (adv_i)
                    w_nextState = IDLE;
            end
            HALT: w_nextState = HALT;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= IDLE;
            r_load     <= 32'd0;
            r_misalign <= 1'b0;
            r_err      <= 1'b0;
            r_halt     <= 1'b0;
            r_stallCnt <= '0;
            r_waitCnt  <= 32'd0;
        end else begin
            r_state    <= w_nextState;
            r_misalign <= w_misalign;
            if (w_capture)
                r_load <= dmemload;
            if ((r_state == IDLE) && halt_i)
                r_halt <= 1'b1;
            if (w_timeout)
                r_err <= 1'b1;
            if (mem_stall && (r_stallCnt != {CNT_W{1'b1}}))
                r_stallCnt <= r_stallCnt + 1'b1;
            // Wait counter runs only inside ACCESS, so entering ACCESS always starts from zero.
            if (r_state != ACCESS)
                r_waitCnt <= 32'd0;
            else if (r_waitCnt != 32'hFFFF_FFFF)
                r_waitCnt <= r_waitCnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_mem_stage_access_ctrl.sv
// Self-checking bench for mem_stage_access_ctrl; load data expectations flow through a
// scoreboard queue filled when a hit is driven and drained when load_o updates.
module tb_mem_stage_access_ctrl;

    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 4;

    logic             CLK;
    logic             RST;
    logic             ren_i;
    logic             wen_i;
    logic [31:0]      addr_i;
    logic [31:0]      store_i;
    logic             halt_i;
    logic             adv_i;
    logic             dhit;
    logic [31:0]      dmemload;
    logic             dmemREN;
    logic             dmemWEN;
    logic [31:0]      dmemaddr;
    logic [31:0]      dmemstore;
    logic [31:0]      load_o;
    logic             mem_stall;
    logic             misalign_o;
    logic             err_o;
    logic             halt_o;
    logic [CNT_W-1:0] stall_cnt;

    int          vectors;
    int          miscompares;
    logic [31:0] expQ[$];

    mem_stage_access_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST(RST),
        .ren_i(ren_i), .wen_i(wen_i), .addr_i(addr_i), .store_i(store_i),
        .halt_i(halt_i), .adv_i(adv_i), .dhit(dhit), .dmemload(dmemload),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .load_o(load_o), .mem_stall(mem_stall), .misalign_o(misalign_o),
        .err_o(err_o), .halt_o(halt_o), .stall_cnt(stall_cnt)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic clearInputs();
        ren_i = 0; wen_i = 0; addr_i = 0; store_i = 0;
        halt_i = 0; adv_i = 1; dhit = 0; dmemload = 0;
    endtask

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyReset();
        clearInputs();
        RST = 1;
        cycle();
        cycle();
        RST = 0;
    endtask

    task automatic popLoad(input string name);
        logic [31:0] exp;
        vectors++;
        if (expQ.size() == 0) begin
            $display("[TB] FAIL %s: scoreboard empty, load_o=%h", name, load_o);
            miscompares++;
        end else begin
            exp = expQ.pop_front();
            if (load_o !== exp) begin
                $display("[TB] FAIL %s: load_o=%h expected %h", name, load_o, exp);
                miscompares++;
            end
        end
    endtask

    task automatic test_reset();
        applyReset();
        @(negedge CLK);
        vectors++;
        if ({load_o, misalign_o, err_o, halt_o, stall_cnt, dmemREN, dmemWEN, mem_stall} !==
            {32'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0}) begin
            $display("[TB] FAIL reset_state: load=%h mis=%b err=%b halt=%b cnt=%0d ren=%b wen=%b stall=%b expected all zero",
                     load_o, misalign_o, err_o, halt_o, stall_cnt, dmemREN, dmemWEN, mem_stall);
            miscompares++;
        end
        cycle();
    endtask

    task automatic test_load_hit();
        applyReset();
        ren_i = 1; addr_i = 32'h100; dhit = 1; dmemload = 32'hDEADBEEF; adv_i = 1;
        @(negedge CLK);
        vectors++;
        if (dmemREN !== 1'b1 || dmemWEN !== 1'b0 || mem_stall !== 1'b0 || dmemaddr !== 32'h100) begin
            $display("[TB] FAIL load_hit_req: ren=%b wen=%b stall=%b addr=%h expected 1 0 0 00000100",
                     dmemREN, dmemWEN, mem_stall, dmemaddr);
            miscompares++;
        end
        expQ.push_back(32'hDEADBEEF);
        cycle();
        clearInputs();
        popLoad("load_hit_data");
        vectors++;
        if (stall_cnt !== 4'd0) begin
            $display("[TB] FAIL load_hit_cnt: stall_cnt=%0d expected 0", stall_cnt);
            miscompares++;
        end
    endtask

    task automatic test_store_wait();
        applyReset();
        wen_i = 1; ren_i = 1; addr_i = 32'h204; store_i = 32'h12345678; adv_i = 1;
        dmemload = 32'hBAADF00D;
        for (int k = 0; k < 4; k++) begin
            dhit = (k == 3);
            @(negedge CLK);
            vectors++;
            if (dmemWEN !== 1'b1 || dmemREN !== 1'b0 || dmemstore !== 32'h12345678 ||
                dmemaddr !== 32'h204 || mem_stall !== (k < 3)) begin
                $display("[TB] FAIL store_wait_c%0d: wen=%b ren=%b data=%h addr=%h stall=%b expected 1 0 12345678 00000204 %b",
                         k, dmemWEN, dmemREN, dmemstore, dmemaddr, mem_stall, (k < 3));
                miscompares++;
            end
            cycle();
        end
        clearInputs();
        @(negedge CLK);
        vectors++;
        if (stall_cnt !== 4'd3 || dmemWEN !== 1'b0 || load_o !== 32'd0 || err_o !== 1'b0) begin
            $display("[TB] FAIL store_wait_end: cnt=%0d wen=%b load=%h err=%b expected 3 0 00000000 0",
                     stall_cnt, dmemWEN, load_o, err_o);
            miscompares++;
        end
        cycle();
    endtask

    task automatic test_hold();
        applyReset();
        ren_i = 1; addr_i = 32'h40; dhit = 1; dmemload = 32'hCAFEF00D; adv_i = 0;
        @(negedge CLK);
        vectors++;
        if (dmemREN !== 1'b1 || mem_stall !== 1'b0) begin
            $display("[TB] FAIL hold_first: ren=%b stall=%b expected 1 0", dmemREN, mem_stall);
            miscompares++;
        end
        expQ.push_back(32'hCAFEF00D);
        cycle();
        dmemload = 32'h0BADBAD0;
        popLoad("hold_capture");
        for (int k = 0; k < 3; k++) begin
            adv_i = (k == 2);
            @(negedge CLK);
            vectors++;
            if (dmemREN !== 1'b0 || mem_stall !== 1'b0 || load_o !== 32'hCAFEF00D) begin
                $display("[TB] FAIL hold_c%0d: ren=%b stall=%b load=%h expected 0 0 cafef00d",
                         k, dmemREN, mem_stall, load_o);
                miscompares++;
            end
            cycle();
        end
        addr_i = 32'h44; dmemload = 32'h11111111; adv_i = 1;
        @(negedge CLK);
        vectors++;
        if (dmemREN !== 1'b1 || dmemaddr !== 32'h44) begin
            $display("[TB] FAIL hold_release: ren=%b addr=%h expected 1 00000044", dmemREN, dmemaddr);
            miscompares++;
        end
        expQ.push_back(32'h11111111);
        cycle();
        clearInputs();
        popLoad("hold_next_load");
    endtask

    task automatic test_misalign_halt();
        applyReset();
        ren_i = 1; addr_i = 32'h103; dhit = 1; dmemload = 32'h55555555;
        @(negedge CLK);
        vectors++;
        if (dmemREN !== 1'b0 || mem_stall !== 1'b0 || misalign_o !== 1'b0) begin
            $display("[TB] FAIL misalign_req: ren=%b stall=%b mis=%b expected 0 0 0", dmemREN, mem_stall, misalign_o);
            miscompares++;
        end
        cycle();
        clearInputs();
        vectors++;
        if (misalign_o !== 1'b1 || load_o !== 32'd0) begin
            $display("[TB] FAIL misalign_pulse: mis=%b load=%h expected 1 00000000", misalign_o, load_o);
            miscompares++;
        end
        cycle();
        vectors++;
        if (misalign_o !== 1'b0) begin
            $display("[TB] FAIL misalign_clear: mis=%b expected 0", misalign_o);
            miscompares++;
        end
        halt_i = 1; wen_i = 1; addr_i = 32'h200; store_i = 32'hA5A5A5A5; dhit = 0;
        @(negedge CLK);
        vectors++;
        if (dmemWEN !== 1'b0 || mem_stall !== 1'b0 || halt_o !== 1'b0) begin
            $display("[TB] FAIL halt_req: wen=%b stall=%b halt=%b expected 0 0 0", dmemWEN, mem_stall, halt_o);
            miscompares++;
        end
        cycle();
        clearInputs();
        ren_i = 1; addr_i = 32'h300; dhit = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            vectors++;
            if (halt_o !== 1'b1 || dmemREN !== 1'b0 || mem_stall !== 1'b0) begin
                $display("[TB] FAIL halt_sticky_c%0d: halt=%b ren=%b stall=%b expected 1 0 0", k, halt_o, dmemREN, mem_stall);
                miscompares++;
            end
            cycle();
        end
        applyReset();
        vectors++;
        if (halt_o !== 1'b0) begin
            $display("[TB] FAIL halt_reset: halt=%b expected 0", halt_o);
            miscompares++;
        end
    endtask

    task automatic test_timeout_reset();
        applyReset();
        ren_i = 1; addr_i = 32'h300; dhit = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            vectors++;
            if (err_o !== (k >= 5) || dmemREN !== 1'b1 || mem_stall !== 1'b1) begin
                $display("[TB] FAIL timeout_c%0d: err=%b ren=%b stall=%b expected %b 1 1", k, err_o, dmemREN, mem_stall, (k >= 5));
                miscompares++;
            end
            if (k < 5) cycle();
        end
        vectors++;
        if (stall_cnt !== 4'd5) begin
            $display("[TB] FAIL timeout_cnt: stall_cnt=%0d expected 5", stall_cnt);
            miscompares++;
        end
        cycle();
        RST = 1;
        @(negedge CLK);
        vectors++;
        if (dmemREN !== 1'b1 || dmemaddr !== 32'h300) begin
            $display("[TB] FAIL reset_cycle_req: ren=%b addr=%h expected 1 00000300", dmemREN, dmemaddr);
            miscompares++;
        end
        cycle();
        RST = 0;
        clearInputs();
        @(negedge CLK);
        vectors++;
        if (dmemREN !== 1'b0 || err_o !== 1'b0 || stall_cnt !== 4'd0 || load_o !== 32'd0) begin
            $display("[TB] FAIL after_reset: ren=%b err=%b cnt=%0d load=%h expected 0 0 0 00000000", dmemREN, err_o, stall_cnt, load_o);
            miscompares++;
        end
        cycle();
        ren_i = 1; addr_i = 32'h8; dhit = 1; dmemload = 32'h77778888;
        @(negedge CLK);
        vectors++;
        if (dmemREN !== 1'b1 || mem_stall !== 1'b0) begin
            $display("[TB] FAIL after_reset_idle: ren=%b stall=%b expected 1 0", dmemREN, mem_stall);
            miscompares++;
        end
        expQ.push_back(32'h77778888);
        cycle();
        clearInputs();
        popLoad("after_reset_load");
    endtask

    task automatic test_saturation();
        int expCnt;
        applyReset();
        expCnt = 0;
        ren_i = 1; addr_i = 32'h400; dhit = 0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (expCnt < 15) expCnt++;
            if (k >= 13) begin
                vectors++;
                if (stall_cnt !== 4'(expCnt)) begin
                    $display("[TB] FAIL sat_c%0d: stall_cnt=%0d expected %0d", k, stall_cnt, expCnt);
                    miscompares++;
                end
            end
        end
        dhit = 1;
        cycle();
        clearInputs();
        vectors++;
        if (stall_cnt !== 4'd15) begin
            $display("[TB] FAIL sat_final: stall_cnt=%0d expected 15", stall_cnt);
            miscompares++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] data;
        applyReset();
        for (int k = 0; k < 8; k++) begin
            data = $urandom;
            ren_i = 1; wen_i = 0; addr_i = 32'(k * 4 + 32'h500); dhit = 1; dmemload = data; adv_i = 1;
            @(negedge CLK);
            vectors++;
            if (dmemREN !== 1'b1 || mem_stall !== 1'b0 || dmemaddr !== 32'(k * 4 + 32'h500)) begin
                $display("[TB] FAIL b2b_req_%0d: ren=%b stall=%b addr=%h", k, dmemREN, mem_stall, dmemaddr);
                miscompares++;
            end
            expQ.push_back(data);
            cycle();
            popLoad("b2b_load");
        end
        clearInputs();
        vectors++;
        if (expQ.size() != 0 || stall_cnt !== 4'd0) begin
            $display("[TB] FAIL b2b_end: leftover=%0d cnt=%0d expected 0 0", expQ.size(), stall_cnt);
            miscompares++;
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        RST = 1;
        clearInputs();
        test_reset();
        test_load_hit();
        test_store_wait();
        test_hold();
        test_misalign_halt();
        test_timeout_reset();
        test_saturation();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_stage_access_ctrl.md
Name: mem_stage_access_ctrl

Overview:
- Consumer end of the EX/MEM pipeline latch in the pipelined MIPS datapath.
- Reads the latched memory controls (read enable, write enable, address, store data, halt) and drives the datapath-side dcache request signals.
- Holds the pipeline with mem_stall until dhit, captures load data for MEM/WB, and prevents a completed access from re-issuing while the pipeline is frozen by other hazards.
- Also flags misaligned word accesses, counts stall cycles and latches halt.

Parameters:
CNT_W, 16, width of the saturating stall-cycle counter
TIMEOUT, 64, cycles in ACCESS without dhit before err_o sets; 0 disables the timeout

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  synchronous, active-high reset
ren_i  input  1  latched dREN from EX/MEM
wen_i  input  1  latched dWEN from EX/MEM
addr_i  input  32  latched ALU result (byte address)
store_i  input  32  latched rdat2 (store data)
halt_i  input  1  latched halt from EX/MEM
adv_i  input  1  EX/MEM latch loads a new instruction at the next edge when mem_stall=0
dhit  input  1  dcache access complete this cycle
dmemload  input  32  dcache read data, valid when dhit=1
dmemREN  output  1  dcache read request
dmemWEN  output  1  dcache write request
dmemaddr  output  32  dcache address
dmemstore  output  32  dcache write data
load_o  output  32  registered load data for MEM/WB
mem_stall  output  1  freeze upstream pipeline
misalign_o  output  1  one-cycle pulse on a misaligned access
err_o  output  1  sticky timeout error
halt_o  output  1  sticky halt
stall_cnt  output  CNT_W  saturating count of mem_stall cycles

Behaviour:
- State register: IDLE, ACCESS, HOLD, HALT.
- Reset: state goes to IDLE. load_o, misalign_o, err_o, halt_o, stall_cnt and the wait counter clear to 0.
- Reset mid-access: in the reset cycle the FSM is still in ACCESS, so the request is still driven. The request drops in the cycle after the reset edge. Captured data is discarded.
- Definitions:
  - op = ren_i | wen_i.
  - aligned = (addr_i[1:0] == 2'b00).
  - req = op & aligned & ~halt_i, evaluated in IDLE or ACCESS.
- If wen_i and ren_i are both set, the write wins: dmemWEN=1, dmemREN=0.
- Request outputs are combinational. When req is active:
  - dmemREN = ren_i & ~wen_i.
  - dmemWEN = wen_i.
  - dmemaddr = addr_i.
  - dmemstore = store_i.
  - Otherwise all four are 0.
- mem_stall = req & ~dhit, combinational. Zero latency when dhit arrives in the same cycle as the request.
- IDLE:
  - If halt_i: go to HALT. halt_o=1 from the next cycle. No request is issued, even if op is set.
  - Else if op & ~aligned: no request. misalign_o=1 for the next cycle only. Stay in IDLE.
  - Else if req & dhit: load_o <= dmemload when reading (unchanged on a write). Stay in IDLE if adv_i, else go to HOLD.
  - Else if req & ~dhit: go to ACCESS. The wait counter clears.
- ACCESS:
  - Request held and the wait counter increments each cycle.
  - If TIMEOUT != 0 and the wait counter reaches TIMEOUT-1 without dhit: err_o <= 1 (sticky until RST). Continue waiting.
  - On dhit: capture as in IDLE. Go to IDLE if adv_i, else go to HOLD.
- HOLD:
  - No request and mem_stall=0. load_o is held.
  - Go to IDLE on the first cycle with adv_i=1.
- HALT: absorbing. No requests, mem_stall=0, halt_o=1. Only RST exits.
- stall_cnt: +1 on each cycle with mem_stall=1. Saturates at 2^CNT_W-1 and never wraps.
- misalign_o does not stall. The instruction is treated as completed with no memory side effect.

Test Plan:
- Load hit in the same cycle: ren_i=1, addr_i=0x100, dhit=1, dmemload=0xDEADBEEF, adv_i=1 -> dmemREN=1, mem_stall=0; load_o=0xDEADBEEF next cycle; stall_cnt=0.
- Store miss with 3-cycle wait: wen_i=1, addr_i=0x204, store_i=0x12345678, dhit high on the 4th cycle -> dmemWEN=1 and dmemstore=0x12345678 for 4 cycles; mem_stall=1 for 3 cycles; stall_cnt=3.
- Hit while frozen: load hits with adv_i=0 for 2 more cycles -> state HOLD, dmemREN=0 during those cycles (no re-issue); load_o stable; IDLE once adv_i=1.
- Misaligned access plus halt: ren_i=1, addr_i=0x103 -> no request, misalign_o=1 for exactly one cycle. Then halt_i=1 with wen_i=1 -> no dmemWEN; halt_o stays 1 until RST.
- Timeout and reset: TIMEOUT=4, ren_i=1, dhit held at 0 -> err_o=1 after 4 ACCESS cycles; RST asserted in ACCESS -> request still driven in the reset cycle; after the edge dmemREN=0, err_o=0, stall_cnt=0, state IDLE.
- Saturation: CNT_W=4, stall for 20 cycles -> stall_cnt=15.
